// File: rtl/serial_demux_pkg.sv
// Shared definitions for the serial 1:8 deserializer.
//   FRAME_W  : bits per assembled frame
//   IDX_W    : width of the bit-index counter
//   state_t  : deserializer FSM states
//   map_idx  : arrival order -> byte position
package serial_demux_pkg;

  localparam int FRAME_W = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Byte position for the i-th bit of a frame. With a 3-bit index, ~i is 7-i.
  function automatic logic [IDX_W-1:0] map_idx(input logic [IDX_W-1:0] i,
                                               input logic lsb_first);
    return lsb_first ? i : ~i;
  endfunction

endpackage

// File: rtl/bit_demux1x8.sv
// Combinational 1:8 bit demultiplexer, the receive-side counterpart of the
// 8:1 bit select.
//   idx  : target byte position
//   d    : data bit
//   we   : one-hot write enable for position idx
//   data : d replicated to every position
module bit_demux1x8
  import serial_demux_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               d,
  output logic [FRAME_W-1:0] we,
  output logic [FRAME_W-1:0] data
);

  always_comb begin
    we      = '0;
    we[idx] = 1'b1;
  end

  assign data = {FRAME_W{d}};

endmodule

// File: rtl/serial_demux8.sv
// Serial-to-parallel 1:8 deserializer with a valid/ready byte output.
//   clk, rst_n  : clock, synchronous active-low reset
//   din         : serial bit, qualified by din_valid
//   frame_start : with din_valid, din is bit 0 of a new frame
//   dout        : assembled byte, dout_valid marks it unconsumed
//   dout_ready  : consumer accepts dout
//   bit_idx     : bits received in the current frame (0 when idle)
//   busy        : FSM is in COLLECT
//   overrun     : pulse, a completed byte was dropped (dout still occupied)
//   sync_err    : pulse, a partial frame was discarded by frame_start
//
// Handshake: a byte transfers on every cycle where dout_valid && dout_ready
// are both high at the rising edge; dout is held stable while dout_valid is
// high, and a completion on the same edge as a transfer reloads dout.
module serial_demux8
  import serial_demux_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               frame_start,
  output logic [FRAME_W-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [IDX_W-1:0]   bit_idx,
  output logic               busy,
  output logic               overrun,
  output logic               sync_err
);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     bit_idx_nxt;
  logic [IDX_W-1:0]     wr_idx;
  logic [FRAME_W-1:0]   staging, staging_nxt;
  logic [FRAME_W-1:0]   wr_en, wr_data;
  logic                 start, take, complete, load;

  assign start    = din_valid && frame_start;
  assign take     = din_valid && !frame_start && (state == COLLECT);
  assign complete = take && (bit_idx == IDX_W'(FRAME_W - 1));
  // A completion may land only if the output slot is free or emptying now.
  assign load     = complete && (!dout_valid || dout_ready);

  // A frame_start always writes position map(0), regardless of bit_idx.
  assign wr_idx   = start ? map_idx('0, LSB_FIRST) : map_idx(bit_idx, LSB_FIRST);

  bit_demux1x8 u_demux (
    .idx  (wr_idx),
    .d    (din),
    .we   (wr_en),
    .data (wr_data)
  );

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    staging_nxt = staging;
    case (state)
      IDLE: begin
        if (start) begin
          staging_nxt = wr_data & wr_en;
          bit_idx_nxt = IDX_W'(1);
          state_nxt   = COLLECT;
        end
      end
      COLLECT: begin
        if (start) begin
          // Restart: the partial frame is discarded.
          staging_nxt = wr_data & wr_en;
          bit_idx_nxt = IDX_W'(1);
        end else if (take) begin
          staging_nxt = (staging & ~wr_en) | (wr_data & wr_en);
          bit_idx_nxt = bit_idx + IDX_W'(1);
          if (complete) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_idx    <= '0;
      staging    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_idx  <= bit_idx_nxt;
      staging  <= staging_nxt;
      overrun  <= complete && !load;
      sync_err <= start && (state == COLLECT);
      if (load) begin
        dout       <= staging_nxt;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_serial_demux8.sv
// Bench for serial_demux8: an LSB-first and an MSB-first instance share the
// same stimulus; expected bytes come from the bench's own bit ordering model.
module tb_serial_demux8;

  logic       clk = 1'b0;
  logic       rst_n, din, din_valid, frame_start, dout_ready;
  logic [7:0] dout_l, dout_m;
  logic       dv_l, dv_m, busy_l, busy_m, ovr_l, ovr_m, serr_l, serr_m;
  logic [2:0] idx_l, idx_m;

  int checks = 0;
  int failures = 0;
  int n_ovr_l = 0, n_ovr_m = 0, n_serr_l = 0, n_xfer_m = 0;

  always #5 clk = ~clk;

  serial_demux8 #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .dout(dout_l), .dout_valid(dv_l),
    .dout_ready(dout_ready), .bit_idx(idx_l), .busy(busy_l),
    .overrun(ovr_l), .sync_err(serr_l)
  );

  serial_demux8 #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .dout(dout_m), .dout_valid(dv_m),
    .dout_ready(dout_ready), .bit_idx(idx_m), .busy(busy_m),
    .overrun(ovr_m), .sync_err(serr_m)
  );

  // Pulse and transfer counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (ovr_l) n_ovr_l++;
    if (ovr_m) n_ovr_m++;
    if (serr_l) n_serr_l++;
    if (dv_m && dout_ready) n_xfer_m++;
  end

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle just after it.
  task automatic step(input logic rn, input logic dv, input logic fs,
                      input logic d, input logic rdy);
    rst_n = rn; din_valid = dv; frame_start = fs; din = d; dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Send byte b, bit 0 first when lsb is set, else bit 7 first.
  task automatic send_byte(input logic [7:0] b, input logic lsb, input logic rdy);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, (i == 0), lsb ? b[i] : b[7-i], rdy);
  endtask

  typedef struct {
    logic       rn, dv, fs, d, rdy;
    logic [7:0] e_dout;   // LSB-first instance
    logic [7:0] e_dout_m; // MSB-first instance
    logic       e_dv;
    logic [2:0] e_idx;
    logic       e_busy, e_ovr, e_serr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rn, dv, fs, d, rdy,
                              input logic [7:0] e_dout, e_dout_m,
                              input logic e_dv, input logic [2:0] e_idx,
                              input logic e_busy, e_ovr, e_serr);
    vec_t v;
    v.rn = rn; v.dv = dv; v.fs = fs; v.d = d; v.rdy = rdy;
    v.e_dout = e_dout; v.e_dout_m = e_dout_m; v.e_dv = e_dv; v.e_idx = e_idx;
    v.e_busy = e_busy; v.e_ovr = e_ovr; v.e_serr = e_serr;
    tbl.push_back(v);
  endfunction

  initial begin
    int o0, om0, s0, x0;
    logic [7:0] a5_bits;
    a5_bits = 8'hA5;

    // Reset dominates even with a frame_start present.
    add(0,1,1,1,1, 8'h00,8'h00, 0,3'd0, 0,0,0);
    add(0,1,1,1,1, 8'h00,8'h00, 0,3'd0, 0,0,0);
    // Stray bit without frame_start in IDLE is ignored.
    add(1,1,0,1,1, 8'h00,8'h00, 0,3'd0, 0,0,0);
    // 0xA5 LSB-first, consecutive cycles (stream 1,0,1,0,0,1,0,1).
    for (int i = 0; i < 8; i++)
      add(1,1,(i==0),a5_bits[i],1,
          (i==7) ? 8'hA5 : 8'h00, (i==7) ? rev8(8'hA5) : 8'h00,
          (i==7), (i==7) ? 3'd0 : 3'(i+1), (i!=7), 0,0);
    add(1,0,0,0,1, 8'hA5,rev8(8'hA5), 0,3'd0, 0,0,0);
    // Same frame with a 3-cycle gap after bit 4; busy holds.
    for (int i = 0; i < 4; i++)
      add(1,1,(i==0),a5_bits[i],1, 8'hA5,rev8(8'hA5), 0,3'(i+1), 1,0,0);
    for (int i = 0; i < 3; i++)
      add(1,0,0,1,1, 8'hA5,rev8(8'hA5), 0,3'd4, 1,0,0);
    for (int i = 4; i < 8; i++)
      add(1,1,0,a5_bits[i],1, 8'hA5,rev8(8'hA5),
          (i==7), (i==7) ? 3'd0 : 3'(i+1), (i!=7), 0,0);
    add(1,0,0,0,1, 8'hA5,rev8(8'hA5), 0,3'd0, 0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].dv, tbl[i].fs, tbl[i].d, tbl[i].rdy);
      check($sformatf("row%0d dout_l", i), dout_l, tbl[i].e_dout);
      check($sformatf("row%0d dout_m", i), dout_m, tbl[i].e_dout_m);
      check($sformatf("row%0d dout_valid", i), 8'(dv_l), 8'(tbl[i].e_dv));
      check($sformatf("row%0d bit_idx", i), 8'(idx_l), 8'(tbl[i].e_idx));
      check($sformatf("row%0d busy", i), 8'(busy_l), 8'(tbl[i].e_busy));
      check($sformatf("row%0d overrun", i), 8'(ovr_l), 8'(tbl[i].e_ovr));
      check($sformatf("row%0d sync_err", i), 8'(serr_l), 8'(tbl[i].e_serr));
    end

    // Backpressure: 0x3C held, 0xFF dropped with one overrun pulse.
    o0 = n_ovr_l;
    send_byte(8'h3C, 1'b1, 1'b0);
    check("bp first valid", 8'(dv_l), 8'd1);
    check("bp first dout", dout_l, 8'h3C);
    check("bp first dout_m", dout_m, rev8(8'h3C));
    send_byte(8'hFF, 1'b1, 1'b0);
    check("bp overrun pulse", 8'(ovr_l), 8'd1);
    check("bp dout held", dout_l, 8'h3C);
    check("bp valid held", 8'(dv_l), 8'd1);
    step(1, 0, 0, 0, 0);
    check("bp overrun clears", 8'(ovr_l), 8'd0);
    check("bp dout still held", dout_l, 8'h3C);
    check("bp overrun count", 8'(n_ovr_l - o0), 8'd1);
    step(1, 0, 0, 0, 1);
    check("bp valid drops", 8'(dv_l), 8'd0);

    // Resync: 5 bits then a fresh frame 0x81.
    o0 = n_ovr_l; s0 = n_serr_l;
    for (int i = 0; i < 5; i++) step(1, 1, (i == 0), 1'b1, 1);
    check("sync partial idx", 8'(idx_l), 8'd5);
    send_byte(8'h81, 1'b1, 1'b1);
    check("sync dout", dout_l, 8'h81);
    check("sync dout_m", dout_m, rev8(8'h81));
    check("sync valid", 8'(dv_l), 8'd1);
    check("sync_err count", 8'(n_serr_l - s0), 8'd1);
    check("sync no overrun", 8'(n_ovr_l - o0), 8'd0);

    // Reset mid-frame with a byte still pending.
    for (int i = 0; i < 6; i++) step(1, 1, (i == 0), 1'b0, 0);
    check("rst pre idx", 8'(idx_l), 8'd6);
    check("rst pre pending", 8'(dv_l), 8'd1);
    step(0, 0, 0, 0, 0);
    check("rst dout", dout_l, 8'h00);
    check("rst valid", 8'(dv_l), 8'd0);
    check("rst idx", 8'(idx_l), 8'd0);
    check("rst busy", 8'(busy_l), 8'd0);
    check("rst overrun", 8'(ovr_l), 8'd0);
    check("rst sync_err", 8'(serr_l), 8'd0);
    check("rst dout_m", dout_m, 8'h00);
    check("rst busy_m", 8'(busy_m), 8'd0);
    step(1, 0, 0, 0, 1);
    send_byte(8'h5A, 1'b1, 1'b1);
    check("post rst dout", dout_l, 8'h5A);
    check("post rst dout_m", dout_m, rev8(8'h5A));
    step(1, 0, 0, 0, 1);

    // MSB-first back-to-back frames with dout_ready held high.
    x0 = n_xfer_m; om0 = n_ovr_m;
    send_byte(8'hC3, 1'b0, 1'b1);
    check("msb c3 dout_m", dout_m, 8'hC3);
    check("msb c3 valid", 8'(dv_m), 8'd1);
    check("msb c3 dout_l", dout_l, rev8(8'hC3));
    send_byte(8'h0F, 1'b0, 1'b1);
    check("msb 0f dout_m", dout_m, 8'h0F);
    check("msb 0f dout_l", dout_l, rev8(8'h0F));
    check("msb 0f valid", 8'(dv_m), 8'd1);
    check("msb 0f idx", 8'(idx_m), 8'd0);
    step(1, 0, 0, 0, 1);
    check("msb valid drops", 8'(dv_m), 8'd0);
    check("msb transfers", 8'(n_xfer_m - x0), 8'd2);
    check("msb no overrun", 8'(n_ovr_m - om0), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
